// File: rtl/adder_result_display.sv
// Seven-segment display stage for the 4-bit adder: captures {carry,sum} on a load
// strobe and scans the 5-bit result across a 4-digit active-low common-anode display.
module adder_result_display #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] sum,
    input  logic       carry,
    input  logic       hex_mode,
    output logic [4:0] value,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp
);

    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    logic [4:0]       r_value;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_dsel;
    logic [1:0]       w_dsel_nxt;
    logic             w_wrap;
    logic [1:0]       w_tens;
    logic [3:0]       w_ones;
    logic [3:0]       w_an;
    logic [6:0]       w_seg;
    logic             w_dp;
    logic [3:0]       r_an;
    logic [6:0]       r_seg;
    logic             r_dp;

    // Segment pattern {g,f,e,d,c,b,a}, active-low
    function automatic logic [6:0] f_glyph(input logic [3:0] d);
        case (d)
            4'h0:    f_glyph = 7'b1000000;
            4'h1:    f_glyph = 7'b1111001;
            4'h2:    f_glyph = 7'b0100100;
            4'h3:    f_glyph = 7'b0110000;
            4'h4:    f_glyph = 7'b0011001;
            4'h5:    f_glyph = 7'b0010010;
            4'h6:    f_glyph = 7'b0000010;
            4'h7:    f_glyph = 7'b1111000;
            4'h8:    f_glyph = 7'b0000000;
            4'h9:    f_glyph = 7'b0010000;
            4'hA:    f_glyph = 7'b0001000;
            4'hB:    f_glyph = 7'b0000011;
            4'hC:    f_glyph = 7'b1000110;
            4'hD:    f_glyph = 7'b0100001;
            4'hE:    f_glyph = 7'b0000110;
            default: f_glyph = 7'b0001110;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_value <= '0;
        end else if (load) begin
            r_value <= {carry, sum};
        end
    end

    assign w_wrap = (r_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Scan state machine: the digit select is the only state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dsel <= 2'd0;
        end else begin
            r_dsel <= w_dsel_nxt;
        end
    end

    always_comb begin
        w_dsel_nxt = r_dsel;
        if (w_wrap) begin
            w_dsel_nxt = r_dsel + 2'd1;
        end
    end

    assign w_tens = 2'(r_value / 5'd10);
    assign w_ones = 4'(r_value % 5'd10);

    always_comb begin
        w_an  = 4'b1111;
        w_seg = 7'b1111111;
        w_dp  = 1'b1;
        case (r_dsel)
            2'd0: begin
                w_an  = 4'b1110;
                w_seg = f_glyph(hex_mode ? r_value[3:0] : w_ones);
            end
            2'd1: begin
                if (hex_mode) begin
                    w_an  = 4'b1101;
                    w_seg = f_glyph({3'b000, r_value[4]});
                    w_dp  = ~r_value[4];
                end else if (w_tens != 2'd0) begin
                    // Tens digit blanked when zero in decimal mode
                    w_an  = 4'b1101;
                    w_seg = f_glyph({2'b00, w_tens});
                end
            end
            default: begin
                w_an  = 4'b1111;
                w_seg = 7'b1111111;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_an  <= 4'b1111;
            r_seg <= 7'b1111111;
            r_dp  <= 1'b1;
        end else begin
            r_an  <= w_an;
            r_seg <= w_seg;
            r_dp  <= w_dp;
        end
    end

    assign value = r_value;
    assign seg   = r_seg;
    assign an    = r_an;
    assign dp    = r_dp;

endmodule
